// File: rtl/uart_alu_pkg.sv
// Purpose : shared definitions for the UART command sequencer and the ALU it drives.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: 3-bit sequencer state encoding (WAIT_A..WAIT_TX) and the ALU opcode set.
package uart_alu_pkg;

  localparam int NB_STATE = 3;

  localparam logic [NB_STATE-1:0] ST_WAIT_A  = 3'd0;
  localparam logic [NB_STATE-1:0] ST_WAIT_B  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_WAIT_OP = 3'd2;
  localparam logic [NB_STATE-1:0] ST_EXEC    = 3'd3;
  localparam logic [NB_STATE-1:0] ST_SEND    = 3'd4;
  localparam logic [NB_STATE-1:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [NB_STATE-1:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  // Opcodes understood by the ALU (MIPS-style funct encoding).
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_timeout.sv
// Purpose : inter-byte timeout counter for the UART command sequencer.
// Latency : o_expire is combinational from the count; it asserts on the TIMEOUT_CYCLES-th
//           consecutive enabled cycle after a clear.
// Backpressure: none; the counter saturates at its terminal value until cleared.
// Ports   : clk, i_rst_n (async active-low), i_clear (reset count), i_en (count this cycle),
//           o_expire (terminal count reached while enabled).
module uart_alu_timeout #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] r_cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + NB_CNT'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Purpose : sequencer collecting operand A, operand B and opcode bytes from uart_rx, strobing
//           them into the ALU and handing the result byte to uart_tx.
// Latency : third byte at cycle N -> o_valid at N+1 -> o_tx_start (with o_tx_data) at N+2.
// Backpressure: none upstream; bytes arriving while a result is in flight are dropped, and
//           the next command is accepted once i_tx_done is seen.
// Ports   : clk, i_rst_n (async active-low), i_rx_data/i_rx_done (received byte),
//           i_tx_done (frame sent), i_result (ALU output), o_dato_a/o_dato_b/o_operation/
//           o_valid (ALU request), o_tx_data/o_tx_start (transmit request).
// Option  : define UART_ALU_CTRL_TIMEOUT_EN to abort a partial command after TIMEOUT_CYCLES
//           idle cycles in WAIT_B/WAIT_OP.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_result,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start
);

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_range_check
    $error("uart_alu_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_t             r_state;
  logic [NB_DATA-1:0] r_dato_a;
  logic [NB_DATA-1:0] r_dato_b;
  logic [NB_OP-1:0]   r_operation;
  logic               r_valid;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               w_expire;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic w_tmo_en;
  logic w_tmo_clear;

  // Count only idle cycles of a partially received command; anything else restarts it.
  assign w_tmo_en    = ((r_state == WAIT_B) || (r_state == WAIT_OP)) && !i_rx_done;
  assign w_tmo_clear = !w_tmo_en;

  uart_alu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_tmo_clear),
    .i_en    (w_tmo_en),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= WAIT_A;
      r_dato_a    <= '0;
      r_dato_b    <= '0;
      r_operation <= '0;
      r_valid     <= 1'b0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are set only on the transition that needs them.
      r_valid    <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        WAIT_A: begin
          if (i_rx_done) begin
            r_dato_a <= i_rx_data;
            r_state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            r_dato_b <= i_rx_data;
            r_state  <= WAIT_OP;
          end else if (w_expire) begin
            r_state <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            r_operation <= i_rx_data[NB_OP-1:0];
            r_valid     <= 1'b1;
            r_state     <= EXEC;
          end else if (w_expire) begin
            r_state <= WAIT_A;
          end
        end
        EXEC: begin
          r_tx_data  <= i_result;
          r_tx_start <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          r_state <= WAIT_TX;
        end
        WAIT_TX: begin
          // A byte landing on the same cycle as tx completion starts the next command.
          if (i_tx_done) begin
            if (i_rx_done) begin
              r_dato_a <= i_rx_data;
              r_state  <= WAIT_B;
            end else begin
              r_state <= WAIT_A;
            end
          end
        end
        default: r_state <= WAIT_A;
      endcase
    end
  end

  assign o_dato_a    = r_dato_a;
  assign o_dato_b    = r_dato_b;
  assign o_operation = r_operation;
  assign o_valid     = r_valid;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;

endmodule
